nclic_dispatch: RTL and testbench
=================================

# nclic_dispatch

Priority dispatch stage of the nested interrupt controller. It consumes the per-interrupt configuration vector (priority, enabled, pending) held by the configuration/CSR store. It selects the highest-priority enabled, pending interrupt that exceeds the current running priority, and requests it from the core with a req/ack handshake. A threshold stack tracks nesting: it pushes on each accepted interrupt and pops on each handler return.

## Interface
- `IntAmount`, default `types_pkg::IntAmount` (8): number of interrupt sources.
- `Priorities`, default `types_pkg::Priorities` (8): number of priority levels; also the stack depth.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `int_config_i`  in  `int_config_t [IntAmount]`  live configuration of every source.
- `req_o`  out  1  interrupt request to the core.
- `req_idx_o`  out  `IntIdx`  index of the requested interrupt.
- `req_prio_o`  out  `IntPrio`  priority of the requested interrupt.
- `ack_i`  in  1  core accepts the request; meaningful only while `req_o`=1.
- `ret_i`  in  1  one-cycle pulse on handler return (mret).
- `clear_o`  out  1  one-cycle strobe telling the store to clear the pending bit.
- `clear_idx_o`  out  `IntIdx`  index to clear.
- `threshold_o`  out  `IntPrio`  current running priority.
- `depth_o`  out  `DepthT`  current nesting depth, range 0..Priorities.
- `error_o`  out  1  one-cycle pulse on a protocol violation.

## Operation
- **Eligibility**: a source is eligible when `enabled`=1, `pending`=1 and `prio` > `threshold_o`.
- **Winner selection**: highest `prio` wins. On a tie, the lowest index wins.
- **FSM states**: IDLE, REQ, CLEAR.
- **IDLE**:
  - Eligible source exists: register its idx and prio, then go to REQ.
  - No eligible source: stay in IDLE.
- **REQ**:
  - `req_o`=1 throughout.
  - Each cycle without ack, re-arbitrate: the idx/prio outputs change only to a strictly higher-priority winner.
  - If no source is eligible any more, drop `req_o` and go to IDLE.
  - `req_o && ack_i`:
    - push `threshold_o`;
    - set `threshold_o` to `req_prio_o`;
    - increment `depth_o`;
    - latch `clear_idx_o`;
    - go to CLEAR.
- **CLEAR**: `clear_o`=1 and `req_o`=0 for exactly one cycle, then go to IDLE.
- **Return** (`ret_i`=1, accepted in any state): pop the stack into `threshold_o` and decrement `depth_o`.
  - A return while in REQ lowers the threshold. The next cycle re-arbitrates against the new threshold.
- **Boundaries**:
  - `ret_i` with `depth_o`=0: ignored, `error_o` pulses.
  - Push with `depth_o`=Priorities: the ack is still honoured, the stack is unchanged, `error_o` pulses. This is unreachable under legal priorities.
  - `ack_i` and `ret_i` in the same cycle: the ack is processed, the ret is ignored, `error_o` pulses.
  - `ack_i` without `req_o`: ignored silently.
- **Reset values**:
  - `req_o`, `clear_o`, `error_o`: 0.
  - `req_idx_o`, `req_prio_o`, `clear_idx_o`, `threshold_o`: 0.
  - `depth_o`: 0.
  - Stack contents: 0.
  - FSM: IDLE.
- **Reset mid-operation** (asserted at any depth or state): all of the above return to reset values asynchronously. No `clear_o` is issued.

## Timing
- Config change makes a source eligible in cycle N (FSM in IDLE): `req_o`=1 in cycle N+1.
- Handshake in cycle M:
  - cycle M+1: `clear_o`=1, `threshold_o` and `depth_o` already updated;
  - earliest next `req_o`: cycle M+3.
- `ret_i` in cycle R: `threshold_o`/`depth_o` updated in cycle R+1. A newly eligible lower-priority request appears at R+2.
- `req_idx_o`/`req_prio_o` stay stable in the cycle `ack_i` is sampled.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Structure
- Add to `types_pkg`:
  - `DepthWidth` = `$clog2(Priorities+1)`;
  - `typedef logic [DepthWidth-1:0] DepthT`;
  - `typedef enum logic [1:0] {IDLE, REQ, CLEAR} dispatch_state_t`.
- The arbitration tree is a combinational function inside `nclic_dispatch`.
- Sub-module `nclic_prio_stack`: a LIFO of `IntPrio` with push/pop, depth counter, and full/empty flags.

## Test plan
- **Reset**: assert `rst_n`=0 mid-REQ at depth 2 -> all outputs 0 within the same cycle; they stay 0 after release with no pending sources.
- **Single**: idx 3 prio 2 enabled+pending at cycle N -> `req_o`=1, idx 3, prio 2 at N+1. Ack at M -> `clear_o`=1, `clear_idx_o`=3, `threshold_o`=2, `depth_o`=1 at M+1.
- **Tie and mask**:
  - idx 1 and idx 5 both prio 4 -> idx 1 requested.
  - prio 7 with enabled=0 -> never requested.
  - prio 4 with threshold 4 -> never requested.
- **Nesting**: take prio 2, then pend idx 6 prio 5 -> request idx 6; ack -> `threshold_o`=5, `depth_o`=2. ret -> 2/1; ret -> 0/0.
- **Re-arbitration**: in REQ for prio 3 without ack, pend prio 6 -> `req_prio_o`=6 next cycle. Clear all pending -> `req_o` drops.
- **Errors**:
  - ret at depth 0 -> `error_o` pulse, `threshold_o` stays 0.
  - ack+ret in the same cycle at depth 1 -> `depth_o`=2, `error_o` pulse.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the nested interrupt controller: source configuration, index/priority
// widths, nesting depth and the dispatch FSM encoding.
package types_pkg;

  localparam int unsigned IntAmount  = 8;
  localparam int unsigned Priorities = 8;
  localparam int unsigned IdxWidth   = $clog2(IntAmount);
  localparam int unsigned PrioWidth  = $clog2(Priorities);
  localparam int unsigned DepthWidth = $clog2(Priorities + 1);

  typedef logic [IdxWidth-1:0]   IntIdx;
  typedef logic [PrioWidth-1:0]  IntPrio;
  typedef logic [DepthWidth-1:0] DepthT;

  typedef struct packed {
    IntPrio prio;
    logic   enabled;
    logic   pending;
  } int_config_t;

  typedef enum logic [1:0] {IDLE, REQ, CLEAR} dispatch_state_t;

  typedef struct packed {
    logic   found;
    IntIdx  idx;
    IntPrio prio;
  } arb_result_t;

endpackage

// File: rtl/nclic_prio_stack.sv
// LIFO of saved running priorities; one entry per nesting level.
module nclic_prio_stack
  import types_pkg::*;
#(
  parameter int unsigned Depth  = 8,
  parameter int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  IntPrio            data_i,
  output IntPrio            top_o,
  output logic [DepthW-1:0] depth_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  IntPrio            mem_q [Depth];
  logic [DepthW-1:0] cnt_q;
  logic [AddrW-1:0]  wr_addr;
  logic [AddrW-1:0]  rd_addr;

  assign full_o  = (cnt_q == DepthW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign wr_addr = AddrW'(cnt_q);
  assign rd_addr = AddrW'(cnt_q - 1'b1);
  assign top_o   = empty_o ? '0 : mem_q[rd_addr];
  assign depth_o = cnt_q;

  // Overflowing pushes and underflowing pops leave the stack untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      mem_q[wr_addr] <= data_i;
      cnt_q          <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/nclic_dispatch.sv
// Priority dispatch: picks the best eligible interrupt above the running priority,
// requests it from the core and tracks nesting on a threshold stack.
module nclic_dispatch
  import types_pkg::*;
#(
  parameter int unsigned IntAmount  = types_pkg::IntAmount,
  parameter int unsigned Priorities = types_pkg::Priorities
) (
  input  logic        clk,
  input  logic        rst_n,
  input  int_config_t int_config_i [IntAmount],
  output logic        req_o,
  output IntIdx       req_idx_o,
  output IntPrio      req_prio_o,
  input  logic        ack_i,
  input  logic        ret_i,
  output logic        clear_o,
  output IntIdx       clear_idx_o,
  output IntPrio      threshold_o,
  output DepthT       depth_o,
  output logic        error_o
);

  // Strict '>' while scanning upwards keeps the lowest index on a priority tie.
  function automatic arb_result_t arbitrate(input int_config_t cfg [IntAmount],
                                            input IntPrio thr);
    arb_result_t res;
    res = '0;
    for (int unsigned i = 0; i < IntAmount; i++) begin
      if (cfg[i].enabled && cfg[i].pending && (cfg[i].prio > thr) &&
          (!res.found || (cfg[i].prio > res.prio))) begin
        res.found = 1'b1;
        res.idx   = IntIdx'(i);
        res.prio  = cfg[i].prio;
      end
    end
    return res;
  endfunction

  dispatch_state_t state_q;
  logic            req_q, clear_q, error_q;
  IntIdx           req_idx_q, clear_idx_q;
  IntPrio          req_prio_q, threshold_q;

  arb_result_t win;
  logic        cur_ok;
  logic        push, pop;
  IntPrio      stack_top;
  logic        stack_full, stack_empty;

  assign win    = arbitrate(int_config_i, threshold_q);
  assign cur_ok = int_config_i[req_idx_q].enabled && int_config_i[req_idx_q].pending &&
                  (int_config_i[req_idx_q].prio > threshold_q);
  assign push   = (state_q == REQ) && ack_i;
  assign pop    = ret_i && !push && !stack_empty;

  nclic_prio_stack #(
    .Depth  (Priorities),
    .DepthW (DepthWidth)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (threshold_q),
    .top_o   (stack_top),
    .depth_o (depth_o),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      clear_q     <= 1'b0;
      error_q     <= 1'b0;
      req_idx_q   <= '0;
      req_prio_q  <= '0;
      clear_idx_q <= '0;
      threshold_q <= '0;
    end else begin
      clear_q <= 1'b0;
      error_q <= (ret_i && (push || stack_empty)) || (push && stack_full);
      if (push) begin
        threshold_q <= req_prio_q;
      end else if (pop) begin
        threshold_q <= stack_top;
      end
      case (state_q)
        IDLE: begin
          if (win.found) begin
            state_q    <= REQ;
            req_q      <= 1'b1;
            req_idx_q  <= win.idx;
            req_prio_q <= win.prio;
          end
        end
        REQ: begin
          if (ack_i) begin
            state_q     <= CLEAR;
            req_q       <= 1'b0;
            clear_q     <= 1'b1;
            clear_idx_q <= req_idx_q;
          end else if (!win.found) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else if ((win.prio > req_prio_q) || !cur_ok) begin
            // Only preempt for a strictly better winner, or if ours vanished.
            req_idx_q  <= win.idx;
            req_prio_q <= win.prio;
          end
        end
        CLEAR: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_o       = req_q;
  assign req_idx_o   = req_idx_q;
  assign req_prio_o  = req_prio_q;
  assign clear_o     = clear_q;
  assign clear_idx_o = clear_idx_q;
  assign threshold_o = threshold_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_nclic_dispatch.sv
// Scoreboard bench for nclic_dispatch: stimulus queues expected events with their cycle,
// a negedge monitor turns DUT output changes into events and matches them in order.
module tb_nclic_dispatch;
  import types_pkg::*;

  localparam int KReq = 0, KClr = 1, KErr = 2, KDrop = 3, KThr = 4;

  typedef struct {
    string nm;
    int    kind;
    int    a;
    int    b;
    int    c;
    int    cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int_config_t cfg [IntAmount];
  logic        ack = 1'b0, ret = 1'b0;
  logic        req, clr, err;
  IntIdx       req_idx, clr_idx;
  IntPrio      req_prio, thr;
  DepthT       depth;

  ev_t q[$];
  int  n_cmp = 0, n_fail = 0;
  int  cyc = 0;
  logic   p_req = 1'b0;
  IntIdx  p_idx = '0;
  IntPrio p_prio = '0, p_thr = '0;
  DepthT  p_depth = '0;

  nclic_dispatch #(
    .IntAmount  (IntAmount),
    .Priorities (Priorities)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .int_config_i (cfg),
    .req_o        (req),
    .req_idx_o    (req_idx),
    .req_prio_o   (req_prio),
    .ack_i        (ack),
    .ret_i        (ret),
    .clear_o      (clr),
    .clear_idx_o  (clr_idx),
    .threshold_o  (thr),
    .depth_o      (depth),
    .error_o      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic ex(input string nm, input int k, input int a, input int b, input int c,
                    input int cy);
    ev_t e;
    e.nm = nm; e.kind = k; e.a = a; e.b = b; e.c = c; e.cyc = cy;
    q.push_back(e);
  endtask

  task automatic got(input int k, input int a, input int b, input int c);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected: got kind=%0d (%0d,%0d,%0d) at cyc %0d, required no event",
               k, a, b, c, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d (%0d,%0d,%0d) cyc %0d, required kind=%0d (%0d,%0d,%0d) cyc %0d",
                 e.nm, k, a, b, c, cyc, e.kind, e.a, e.b, e.c, e.cyc);
      end
    end
  endtask

  // Monitor: one event per observable output change, fixed order within a cycle.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got no event by cyc %0d, required at cyc %0d", e.nm, cyc, e.cyc);
      end
      if (clr) got(KClr, int'(clr_idx), int'(thr), int'(depth));
      if (err) got(KErr, 0, int'(thr), int'(depth));
      if (req && (!p_req || req_idx != p_idx || req_prio != p_prio))
        got(KReq, int'(req_idx), int'(req_prio), 0);
      if (!req && p_req && !clr) got(KDrop, 0, 0, 0);
      if (!clr && (thr != p_thr || depth != p_depth)) got(KThr, 0, int'(thr), int'(depth));
    end
    p_req = req; p_idx = req_idx; p_prio = req_prio; p_thr = thr; p_depth = depth;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setc(input int idx, input int prio, input logic en, input logic pend);
    cfg[idx].prio    = IntPrio'(prio);
    cfg[idx].enabled = en;
    cfg[idx].pending = pend;
  endtask

  task automatic chk(input string nm, input int act, input int req_v);
    n_cmp++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req_o"}, int'(req), 0);
    chk({tag, " req_idx_o"}, int'(req_idx), 0);
    chk({tag, " req_prio_o"}, int'(req_prio), 0);
    chk({tag, " clear_o"}, int'(clr), 0);
    chk({tag, " clear_idx_o"}, int'(clr_idx), 0);
    chk({tag, " threshold_o"}, int'(thr), 0);
    chk({tag, " depth_o"}, int'(depth), 0);
    chk({tag, " error_o"}, int'(err), 0);
  endtask

  // Take the current request: ack for one cycle, then the store clears pending.
  task automatic take(input string nm, input int idx, input int prio, input int d);
    ack = 1'b1;
    ex(nm, KClr, idx, prio, d, cyc + 1);
    step(1);
    ack = 1'b0;
    cfg[idx].pending = 1'b0;
    step(2);
  endtask

  task automatic do_ret(input string nm, input int t, input int d);
    ret = 1'b1;
    ex(nm, KThr, 0, t, d, cyc + 1);
    step(1);
    ret = 1'b0;
    step(2);
  endtask

  initial begin
    for (int i = 0; i < IntAmount; i++) cfg[i] = '0;
    #3 rst_n = 1'b0;
    step(2);
    chk_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Single source
    setc(3, 2, 1'b1, 1'b1);
    ex("single req", KReq, 3, 2, 0, cyc + 1);
    step(1);
    take("single clear", 3, 2, 1);

    // Nesting: prio 5 over running prio 2, then unwind
    setc(6, 5, 1'b1, 1'b1);
    ex("nest req", KReq, 6, 5, 0, cyc + 1);
    step(1);
    take("nest clear", 6, 5, 2);
    do_ret("nest ret1", 2, 1);
    do_ret("nest ret0", 0, 0);

    // Tie goes to lowest index; disabled and at-threshold sources stay silent
    setc(1, 4, 1'b1, 1'b1);
    setc(5, 4, 1'b1, 1'b1);
    setc(7, 7, 1'b0, 1'b1);
    ex("tie req", KReq, 1, 4, 0, cyc + 1);
    step(1);
    take("tie clear", 1, 4, 1);
    step(3);
    ret = 1'b1;
    ex("tie ret", KThr, 0, 0, 0, cyc + 1);
    ex("below-thr now req", KReq, 5, 4, 0, cyc + 2);
    step(1);
    ret = 1'b0;
    step(1);
    cfg[5].pending = 1'b0;
    cfg[7].pending = 1'b0;
    ex("withdraw drop", KDrop, 0, 0, 0, cyc + 1);
    step(3);

    // Re-arbitration while waiting for ack
    setc(4, 3, 1'b1, 1'b1);
    ex("rearb req3", KReq, 4, 3, 0, cyc + 1);
    step(1);
    setc(5, 6, 1'b1, 1'b1);
    ex("rearb req6", KReq, 5, 6, 0, cyc + 1);
    step(1);
    setc(1, 6, 1'b1, 1'b1);
    step(2);
    cfg[1].pending = 1'b0;
    cfg[4].pending = 1'b0;
    cfg[5].pending = 1'b0;
    ex("rearb drop", KDrop, 0, 0, 0, cyc + 1);
    step(3);

    // Errors: return underflow, ack+ret collision
    ret = 1'b1;
    ex("ret at depth0", KErr, 0, 0, 0, cyc + 1);
    step(1);
    ret = 1'b0;
    step(2);
    setc(4, 1, 1'b1, 1'b1);
    ex("err req1", KReq, 4, 1, 0, cyc + 1);
    step(1);
    take("err clear1", 4, 1, 1);
    setc(2, 5, 1'b1, 1'b1);
    ex("err req5", KReq, 2, 5, 0, cyc + 1);
    step(1);
    ack = 1'b1;
    ret = 1'b1;
    ex("ack+ret clear", KClr, 2, 5, 2, cyc + 1);
    ex("ack+ret error", KErr, 0, 5, 2, cyc + 1);
    step(1);
    ack = 1'b0;
    ret = 1'b0;
    cfg[2].pending = 1'b0;
    step(2);
    do_ret("err ret1", 1, 1);
    do_ret("err ret0", 0, 0);

    // Reset mid-REQ at depth 2
    setc(3, 2, 1'b1, 1'b1);
    ex("rst req2", KReq, 3, 2, 0, cyc + 1);
    step(1);
    take("rst clear2", 3, 2, 1);
    setc(6, 5, 1'b1, 1'b1);
    ex("rst req5", KReq, 6, 5, 0, cyc + 1);
    step(1);
    take("rst clear5", 6, 5, 2);
    setc(0, 7, 1'b1, 1'b1);
    ex("rst req7", KReq, 0, 7, 0, cyc + 1);
    step(2);
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    for (int i = 0; i < IntAmount; i++) cfg[i] = '0;
    step(2);
    rst_n = 1'b1;
    step(4);
    chk_zero("after release");

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover events: got %0d outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
